// File: rtl/rf_wb_arbiter.sv
// Arbitrates the register-file write port between the WB stage (priority) and a
// buffered secondary source; exports pending-write mask and starvation stall request.
module rf_wb_arbiter #(
  parameter int unsigned FIFO_DEPTH   = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wb_we,
  input  logic [4:0]                    wb_addr,
  input  logic [31:0]                   wb_data,
  input  logic                          sec_valid,
  output logic                          sec_ready,
  input  logic [4:0]                    sec_addr,
  input  logic [31:0]                   sec_data,
  output logic                          rf_we,
  output logic [4:0]                    rf_waddr,
  output logic [31:0]                   rf_wdata,
  output logic [31:0]                   pend_mask,
  output logic                          stall_req,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  logic [4:0]    addr_q [FIFO_DEPTH];
  logic [31:0]   data_q [FIFO_DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          stall_q, stall_d;

  logic empty, full, push, pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(FIFO_DEPTH));
  assign sec_ready = !full;

  // Writes to r0 are acknowledged but never queued.
  assign push = sec_valid && sec_ready && (sec_addr != 5'd0);
  assign pop  = !wb_we && !empty;

  // Write-port grant: pipeline first, otherwise the FIFO head.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = wb_addr;
    rf_wdata = wb_data;
    if (!rst) begin
      if (wb_we) begin
        rf_we = 1'b1;
      end else if (!empty) begin
        rf_we    = 1'b1;
        rf_waddr = addr_q[rptr_q];
        rf_wdata = data_q[rptr_q];
      end
    end
  end

  // Pending mask over the occupied slots, walking from the head.
  always_comb begin
    pend_mask = '0;
    for (int unsigned k = 0; k < FIFO_DEPTH; k++) begin
      if (CW'(k) < count_q) begin
        pend_mask[addr_q[rptr_q + PW'(k)]] = 1'b1;
      end
    end
    pend_mask[0] = 1'b0;
  end

  always_comb begin
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    count_d  = count_q;
    starve_d = starve_q;
    if (push) wptr_d = wptr_q + PW'(1);
    if (pop)  rptr_d = rptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (pop || empty) begin
      starve_d = '0;
    end else if (starve_q < SW'(STARVE_LIMIT)) begin
      starve_d = starve_q + SW'(1);
    end
    stall_d = (starve_d == SW'(STARVE_LIMIT));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      starve_q <= '0;
      stall_q  <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      starve_q <= starve_d;
      stall_q  <= stall_d;
    end
  end

  // Payload storage needs no reset; occupancy is tracked by count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wptr_q] <= sec_addr;
      data_q[wptr_q] <= sec_data;
    end
  end

  assign stall_req  = stall_q;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Randomized and directed checks of rf_wb_arbiter against a queue-based reference model.
module tb_rf_wb_arbiter;
  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_we, sec_valid, sec_ready, rf_we, stall_req;
  logic [4:0]  wb_addr, sec_addr, rf_waddr;
  logic [31:0] wb_data, sec_data, rf_wdata, pend_mask;
  logic [1:0]  fifo_count;

  rf_wb_arbiter #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .sec_valid(sec_valid), .sec_ready(sec_ready),
    .sec_addr(sec_addr), .sec_data(sec_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .pend_mask(pend_mask), .stall_req(stall_req), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  ent_t q[$];
  int   starve;
  bit   stall_m;
  int   total;
  int   bad;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_check(input string tag);
    logic [31:0] pm;
    pm = '0;
    foreach (q[i]) pm = pm | (32'd1 << q[i].a);
    pm[0] = 1'b0;
    if (rst) begin
      chk({tag, "_we"}, 32'(rf_we), 32'd0);
    end else if (wb_we) begin
      chk({tag, "_we"}, 32'(rf_we), 32'd1);
      chk({tag, "_waddr"}, 32'(rf_waddr), 32'(wb_addr));
      chk({tag, "_wdata"}, rf_wdata, wb_data);
    end else if (q.size() > 0) begin
      chk({tag, "_we"}, 32'(rf_we), 32'd1);
      chk({tag, "_waddr"}, 32'(rf_waddr), 32'(q[0].a));
      chk({tag, "_wdata"}, rf_wdata, q[0].d);
    end else begin
      chk({tag, "_we"}, 32'(rf_we), 32'd0);
    end
    chk({tag, "_ready"}, 32'(sec_ready), 32'(q.size() < DEPTH));
    chk({tag, "_count"}, 32'(fifo_count), 32'(q.size()));
    chk({tag, "_pend"}, pend_mask, pm);
    chk({tag, "_stall"}, 32'(stall_req), 32'(stall_m));
  endtask

  // Applies one clock edge to the model using the inputs that were live before it.
  task automatic model_update();
    bit was_empty, accept;
    was_empty = (q.size() == 0);
    accept    = sec_valid && (q.size() < DEPTH);
    if (was_empty || !wb_we) starve = 0;
    else if (starve < LIMIT) starve++;
    if (!wb_we && !was_empty) void'(q.pop_front());
    if (accept && sec_addr != 5'd0) q.push_back('{a: sec_addr, d: sec_data});
    stall_m = (starve == LIMIT);
  endtask

  task automatic cyc(input string tag, input logic we, input logic [4:0] wa, input logic [31:0] wd,
                     input logic sv, input logic [4:0] sa, input logic [31:0] sd);
    wb_we = we; wb_addr = wa; wb_data = wd;
    sec_valid = sv; sec_addr = sa; sec_data = sd;
    #2;
    model_check(tag);
    @(posedge clk);
    model_update();
    #1;
  endtask

  initial begin
    total = 0; bad = 0; starve = 0; stall_m = 0;
    rst = 1'b1;
    wb_we = 0; wb_addr = 0; wb_data = 0;
    sec_valid = 0; sec_addr = 0; sec_data = 0;
    @(posedge clk); #1;
    model_check("reset");
    chk("reset_ready_const", 32'(sec_ready), 32'd1);
    rst = 1'b0;

    // Pipeline write goes straight through
    cyc("t1", 1, 5'd3, 32'hA5, 0, 0, 0);

    // Secondary write lands one cycle after accept
    cyc("t2_acc", 0, 0, 0, 1, 5'd7, 32'h1234);
    chk("t2_acc_rfwe", 32'(rf_we), 32'd1);
    chk("t2_pend", pend_mask, 32'h80);
    cyc("t2_wr", 0, 0, 0, 0, 0, 0);
    cyc("t2_after", 0, 0, 0, 0, 0, 0);

    // Starvation under continuous pipeline writes
    cyc("t3_e5", 1, 5'd1, 32'hB0, 1, 5'd5, 32'h11);
    cyc("t3_e6", 1, 5'd2, 32'hB1, 1, 5'd6, 32'h22);
    for (int i = 0; i < 4; i++) cyc("t3_hold", 1, 5'd4, 32'hC0 + 32'(i), 0, 0, 0);
    chk("t3_stall_const", 32'(stall_req), 32'd1);
    cyc("t3_drop", 0, 0, 0, 0, 0, 0);
    chk("t3_stall_clr", 32'(stall_req), 32'd0);

    // Full FIFO pops while a new request waits for room
    cyc("t4_refill", 1, 5'd8, 32'hD0, 1, 5'd5, 32'h55);
    cyc("t4_full", 0, 0, 0, 1, 5'd9, 32'h99);
    cyc("t4_acc", 0, 0, 0, 1, 5'd9, 32'h99);
    for (int i = 0; i < 3; i++) cyc("t4_drain", 0, 0, 0, 0, 0, 0);

    // Writes to r0 are swallowed
    cyc("t5_zero", 0, 0, 0, 1, 5'd0, 32'hDEAD);
    cyc("t5_after", 0, 0, 0, 0, 0, 0);
    chk("t5_count", 32'(fifo_count), 32'd0);

    // Reset with entries queued discards them
    cyc("t6_q1", 1, 5'd1, 32'h1, 1, 5'd10, 32'hA);
    cyc("t6_q2", 1, 5'd1, 32'h2, 1, 5'd11, 32'hB);
    wb_we = 0; sec_valid = 0; rst = 1'b1;
    #1;
    chk("t6_rst_we", 32'(rf_we), 32'd0);
    chk("t6_rst_count", 32'(fifo_count), 32'd0);
    chk("t6_rst_pend", pend_mask, 32'd0);
    q.delete(); starve = 0; stall_m = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) cyc("t6_post", 0, 0, 0, 0, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic        we, sv;
      logic [4:0]  wa, sa;
      we = ($urandom_range(0, 99) < 55);
      wa = 5'($urandom);
      sv = ($urandom_range(0, 99) < 50);
      sa = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      cyc("rnd", we, wa, $urandom, sv, sa, $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
